// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers.
// Used by the iterative core and its key schedule step.
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_256 = 14;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    HOLD
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_column(
    input logic [31:0] c
  );
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {
      xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
      b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
      b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
      xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)
    };
  endfunction

  // SubBytes fused with ShiftRows; byte 0 is the MSB, column-major.
  function automatic logic [127:0] sub_shift(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One on-the-fly key schedule step for AES-128 or AES-256.
// Produces the next key window and the round key for this round.
module aes_key_step
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic [KEY_BITS-1:0] i_win,
  input  logic [7:0]          i_rcon,
  input  logic                i_rot,
  output logic [KEY_BITS-1:0] o_win,
  output logic [127:0]        o_rkey
);

  logic [31:0] w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  generate
    if (KEY_BITS == 256) begin : g_256
      // Window is {older 4 words, newer 4 words};
      // the newer half is this round's key.
      logic [31:0] w_last;
      logic [31:0] w_rw;
      assign w_last = i_win[31:0];
      assign w_rw   = {w_last[23:0], w_last[31:24]};
      assign w_t    = i_rot
                    ? (sub_word(w_rw) ^ {i_rcon, 24'h0})
                    : sub_word(w_last);
      assign w_n0   = i_win[255:224] ^ w_t;
      assign w_n1   = i_win[223:192] ^ w_n0;
      assign w_n2   = i_win[191:160] ^ w_n1;
      assign w_n3   = i_win[159:128] ^ w_n2;
      assign o_win  = {i_win[127:0],
                       w_n0, w_n1, w_n2, w_n3};
      assign o_rkey = i_win[127:0];
    end else begin : g_128
      // Every step rotates; the step type only matters for 256.
      logic [31:0] w_rw;
      logic        w_unused_rot;
      assign w_unused_rot = i_rot;
      assign w_rw   = {i_win[23:0], i_win[31:24]};
      assign w_t    = sub_word(w_rw) ^ {i_rcon, 24'h0};
      assign w_n0   = i_win[127:96] ^ w_t;
      assign w_n1   = i_win[95:64]  ^ w_n0;
      assign w_n2   = i_win[63:32]  ^ w_n1;
      assign w_n3   = i_win[31:0]   ^ w_n2;
      assign o_win  = {w_n0, w_n1, w_n2, w_n3};
      assign o_rkey = {w_n0, w_n1, w_n2, w_n3};
    end
  endgenerate

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryption core, one round per clock.
// Valid/ready on both sides, with a cached cipher key.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_block,
  input  logic [KEY_BITS-1:0] in_key,
  input  logic                in_new_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_block,
  output logic                busy
);

  localparam int NR = (KEY_BITS == 256) ? NR_256 : NR_128;
  localparam logic [3:0] LAST = 4'(NR);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end
  endgenerate

  state_t r_state;
  state_t w_next;

  logic                r_live;
  logic [127:0]        r_st;
  logic [3:0]          r_rnd;
  logic [KEY_BITS-1:0] r_win;
  logic [7:0]          r_rcon;
  logic [KEY_BITS-1:0] r_cache;
  logic [127:0]        r_out;
  logic                r_ov;

  logic                w_rdy;
  logic                w_acc;
  logic                w_busy;
  logic                w_last;
  logic                w_rcon_adv;
  logic [KEY_BITS-1:0] w_key;
  logic [KEY_BITS-1:0] w_win_nxt;
  logic [127:0]        w_rkey;
  logic [127:0]        w_sr;
  logic [127:0]        w_mc;
  logic [127:0]        w_rnd_out;

  assign w_last = (r_rnd == LAST);
  assign w_key  = in_new_key ? in_key : r_cache;

  // AES-256 only steps rcon on the RotWord (odd) rounds.
  assign w_rcon_adv = (KEY_BITS == 128) | r_rnd[0];

  aes_key_step #(
    .KEY_BITS (KEY_BITS)
  ) u_key_step (
    .i_win  (r_win),
    .i_rcon (r_rcon),
    .i_rot  (r_rnd[0]),
    .o_win  (w_win_nxt),
    .o_rkey (w_rkey)
  );

  assign w_sr      = sub_shift(r_st);
  assign w_mc      = mix_columns(w_sr);
  assign w_rnd_out = (w_last ? w_sr : w_mc) ^ w_rkey;

  assign in_ready  = w_rdy;
  assign busy      = w_busy;
  assign out_valid = r_ov;
  assign out_block = r_out;

  // State register; r_live keeps in_ready low until the first edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  // Handshake decode and next-state selection.
  always_comb begin
    w_next = r_state;
    w_rdy  = r_live &
             ((r_state == IDLE) |
              ((r_state == HOLD) & out_ready));
    w_acc  = in_valid & w_rdy;
    w_busy = (r_state == ROUND);
    unique case (r_state)
      IDLE:  if (w_acc) w_next = ROUND;
      ROUND: if (w_last) w_next = HOLD;
      HOLD:  if (out_ready) w_next = w_acc ? ROUND : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Block load, round iteration and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= '0;
      r_rnd   <= '0;
      r_win   <= '0;
      r_rcon  <= '0;
      r_cache <= '0;
      r_out   <= '0;
      r_ov    <= 1'b0;
    end else begin
      if (r_ov & out_ready) begin
        r_ov <= 1'b0;
      end
      if (w_acc) begin
        if (in_new_key) begin
          r_cache <= in_key;
        end
        r_st   <= in_block ^ w_key[KEY_BITS-1 -: 128];
        r_rnd  <= 4'd1;
        r_win  <= w_key;
        r_rcon <= RCON_INIT;
      end else if (r_state == ROUND) begin
        r_st  <= w_rnd_out;
        r_win <= w_win_nxt;
        if (w_rcon_adv) begin
          r_rcon <= xtime(r_rcon);
        end
        if (w_last) begin
          r_out <= w_rnd_out;
          r_ov  <= 1'b1;
        end else begin
          r_rnd <= r_rnd + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core, 128- and 256-bit builds.
// Reference vectors plus an independent software AES model.
module tb_aes_iter_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_iv, a_ir, a_nk, a_ov, a_or, a_busy;
  logic [127:0] a_blk, a_key, a_out;

  logic         b_iv, b_ir, b_nk, b_ov, b_or, b_busy;
  logic [127:0] b_blk, b_out;
  logic [255:0] b_key;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_sbox [256];

  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CTZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_iter_core #(.KEY_BITS(128)) u128 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_iv),
    .in_ready   (a_ir),
    .in_block   (a_blk),
    .in_key     (a_key),
    .in_new_key (a_nk),
    .out_valid  (a_ov),
    .out_ready  (a_or),
    .out_block  (a_out),
    .busy       (a_busy)
  );

  aes_iter_core #(.KEY_BITS(256)) u256 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_iv),
    .in_ready   (b_ir),
    .in_block   (b_blk),
    .in_key     (b_key),
    .in_new_key (b_nk),
    .out_valid  (b_ov),
    .out_ready  (b_or),
    .out_block  (b_out),
    .busy       (b_busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] x,
                                      input logic [7:0] y);
    logic [7:0] p, a, b;
    p = 8'h00; a = x; b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from the field inverse and affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      ref_sbox[x] = s;
    end
  endtask

  function automatic logic [31:0] ref_sw(input logic [31:0] w);
    return {ref_sbox[w[31:24]], ref_sbox[w[23:16]],
            ref_sbox[w[15:8]], ref_sbox[w[7:0]]};
  endfunction

  // Textbook AES: full expansion up front, byte-array state.
  function automatic logic [127:0] ref_enc(input logic [127:0] pt,
                                           input logic [255:0] key,
                                           input int nk);
    logic [31:0] w [60];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] o;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = ref_sw({tmp[23:0], tmp[31:24]});
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end else if (nk > 4 && i % nk == 4) begin
        tmp = ref_sw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
    for (int rd = 0; rd <= nr; rd++) begin
      if (rd > 0) begin
        for (int k = 0; k < 16; k++) s[k] = ref_sbox[s[k]];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            t[4*c+r] = s[4*((c+r)%4)+r];
        for (int k = 0; k < 16; k++) s[k] = t[k];
        if (rd < nr) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03);
            s[4*c+3] = gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[4*c+j] = s[4*c+j] ^ w[4*rd+c][31-8*j -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Presents one block to the selected core, then scrambles the
  // inputs and waits (bounded) for out_valid. lat=-1 on timeout.
  task automatic run_block(input bit wide,
                           input logic [127:0] blk,
                           input logic [255:0] key,
                           input bit nk,
                           output logic [127:0] res,
                           output int lat);
    int l;
    l = -1;
    res = '0;
    if (wide) begin
      b_iv = 1'b1; b_blk = blk; b_key = key; b_nk = nk;
    end else begin
      a_iv = 1'b1; a_blk = blk; a_key = key[255:128]; a_nk = nk;
    end
    @(posedge clk); #1;
    a_iv = 1'b0; b_iv = 1'b0;
    a_blk = rnd128(); a_key = rnd128(); a_nk = 1'b1;
    b_blk = rnd128(); b_key = {rnd128(), rnd128()}; b_nk = 1'b1;
    for (int n = 1; n <= 40 && l < 0; n++) begin
      @(posedge clk); #1;
      if ((wide ? b_ov : a_ov) === 1'b1) begin
        l = n;
        res = wide ? b_out : a_out;
      end
    end
    lat = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_ir !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready: got %b want 0", a_ir);
    end
    checks++;
    if (a_ov !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid: got %b want 0", a_ov);
    end
    checks++;
    if (a_out !== 128'h0) begin
      errors++; $display("FAIL rst_out_block: got %h want 0", a_out);
    end
    checks++;
    if (a_busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b want 0", a_busy);
    end
    checks++;
    if (b_ir !== 1'b0 || b_ov !== 1'b0) begin
      errors++;
      $display("FAIL rst_256: got ready=%b valid=%b want 0 0", b_ir, b_ov);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_ir !== 1'b1 || b_ir !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready: got %b %b want 1 1", a_ir, b_ir);
    end
  endtask

  task automatic test_fips128();
    logic [127:0] res;
    int lat;
    run_block(1'b0, PT1, {K1, 128'h0}, 1'b1, res, lat);
    checks++;
    if (res !== CT1) begin
      errors++; $display("FAIL fips128_out: got %h want %h", res, CT1);
    end
    checks++;
    if (lat !== 10) begin
      errors++; $display("FAIL fips128_latency: got %0d want 10", lat);
    end
    @(posedge clk); #1;
    checks++;
    if (a_ov !== 1'b0) begin
      errors++; $display("FAIL fips128_consume: got %b want 0", a_ov);
    end
  endtask

  task automatic test_key_cache();
    logic [127:0] res;
    int lat;
    run_block(1'b0, PT2, {K2, 128'h0}, 1'b1, res, lat);
    checks++;
    if (res !== CT2) begin
      errors++; $display("FAIL cache_load: got %h want %h", res, CT2);
    end
    @(posedge clk); #1;
    run_block(1'b0, PT2, {rnd128(), 128'h0}, 1'b0, res, lat);
    checks++;
    if (res !== CT2) begin
      errors++; $display("FAIL cache_reuse: got %h want %h", res, CT2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_aes256();
    logic [127:0] res;
    int lat;
    run_block(1'b1, PT1, K256, 1'b1, res, lat);
    checks++;
    if (res !== CT256) begin
      errors++; $display("FAIL aes256_out: got %h want %h", res, CT256);
    end
    checks++;
    if (lat !== 14) begin
      errors++; $display("FAIL aes256_latency: got %0d want 14", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] res;
    int lat;
    a_or = 1'b0;
    run_block(1'b0, PT2, {K2, 128'h0}, 1'b1, res, lat);
    checks++;
    if (res !== CT2) begin
      errors++; $display("FAIL bp_out: got %h want %h", res, CT2);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (a_ov !== 1'b1 || a_out !== CT2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h",
                 i, a_ov, a_out, CT2);
      end
      checks++;
      if (a_ir !== 1'b0 || a_busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_flags[%0d]: got rdy=%b busy=%b want 0 0",
                 i, a_ir, a_busy);
      end
    end
    a_iv = 1'b1; a_blk = PT1; a_key = K1; a_nk = 1'b1; a_or = 1'b1;
    #1;
    checks++;
    if (a_ir !== 1'b1) begin
      errors++; $display("FAIL bp_ready_up: got %b want 1", a_ir);
    end
    @(posedge clk); #1;
    a_iv = 1'b0;
    checks++;
    if (a_ov !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_swap: got v=%b busy=%b want 0 1", a_ov, a_busy);
    end
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (a_ov === 1'b1) lat = n;
    end
    checks++;
    if (lat !== 10 || a_out !== CT1) begin
      errors++;
      $display("FAIL bp_next: got lat=%0d %h want lat=10 %h",
               lat, a_out, CT1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat, stale;
    a_iv = 1'b1; a_blk = PT2; a_key = K2; a_nk = 1'b1;
    @(posedge clk); #1;
    a_iv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %b want 1", a_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (a_ov !== 1'b0 || a_busy !== 1'b0 || a_ir !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b busy=%b rdy=%b want 0 0 0",
               a_ov, a_busy, a_ir);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_ir !== 1'b1) begin
      errors++; $display("FAIL mid_ready: got %b want 1", a_ir);
    end
    stale = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (a_ov !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++; $display("FAIL mid_stale: got %0d pulses want 0", stale);
    end
    run_block(1'b0, 128'h0, {rnd128(), 128'h0}, 1'b0, res, lat);
    checks++;
    if (res !== CTZ || lat !== 10) begin
      errors++;
      $display("FAIL mid_zero_key: got %h lat=%0d want %h lat=10",
               res, lat, CTZ);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [8];
    logic [127:0] exp_ct [8];
    logic [127:0] outs [8];
    int acc_at [8];
    int acc, got, cyc;
    bit will;
    for (int i = 0; i < 8; i++) begin
      pts[i] = rnd128();
      exp_ct[i] = ref_enc(pts[i], {(i < 4) ? K2 : K1, 128'h0}, 4);
      outs[i] = '0;
      acc_at[i] = 0;
    end
    a_or = 1'b1;
    a_iv = 1'b1; a_blk = pts[0]; a_key = K2; a_nk = 1'b1;
    acc = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 300) begin
      will = a_iv & a_ir;
      @(posedge clk); #1;
      cyc++;
      if (a_ov === 1'b1) begin
        outs[got] = a_out;
        got++;
      end
      if (will) begin
        acc_at[acc] = cyc;
        acc++;
        if (acc < 8) begin
          a_blk = pts[acc];
          a_nk = (acc % 4 == 0);
          a_key = a_nk ? K1 : rnd128();
        end else begin
          a_iv = 1'b0;
        end
      end
    end
    a_iv = 1'b0;
    checks++;
    if (got !== 8 || acc !== 8) begin
      errors++;
      $display("FAIL stream_count: got out=%0d acc=%0d want 8 8", got, acc);
    end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (acc_at[i] - acc_at[i-1] !== 11) begin
        errors++;
        $display("FAIL stream_gap[%0d]: got %0d want 11",
                 i, acc_at[i] - acc_at[i-1]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== exp_ct[i]) begin
        errors++;
        $display("FAIL stream_out[%0d]: got %h want %h",
                 i, outs[i], exp_ct[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_iv = 1'b0; a_nk = 1'b0; a_or = 1'b1;
    a_blk = '0; a_key = '0;
    b_iv = 1'b0; b_nk = 1'b0; b_or = 1'b1;
    b_blk = '0; b_key = '0;
    build_sbox();
    test_reset();
    test_fips128();
    test_key_cache();
    test_aes256();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
